// File: rtl/mem_access_unit_pkg.sv
// Shared types for the LC-3b MEM-stage access unit.
// Memory op encoding, FSM states and op-class helpers.
package mem_access_unit_pkg;

    typedef enum logic [2:0] {
        NONE,
        LDW,
        LDB,
        STW,
        STB,
        LDI,
        STI
    } lc3b_memop;

    typedef enum logic [1:0] {
        IDLE,
        IND,
        ACC
    } lc3b_mau_state;

    typedef logic [1:0] lc3b_mem_wmask;

    function automatic logic is_load(lc3b_memop op);
        return op inside {LDW, LDB, LDI};
    endfunction

    function automatic logic is_indirect(lc3b_memop op);
        return op inside {LDI, STI};
    endfunction

    function automatic logic is_byte(lc3b_memop op);
        return op inside {LDB, STB};
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Memory request/response bundle between the MEM stage and memory.
// The access unit is the master; memory is the slave.
interface mem_access_unit_if;
    import mem_access_unit_pkg::*;

    logic          mem_read;
    logic          mem_write;
    logic [15:0]   mem_address;
    logic [15:0]   mem_wdata;
    lc3b_mem_wmask mem_byte_enable;
    logic          mem_resp;
    logic [15:0]   mem_rdata;

    modport master (
        output mem_read, mem_write, mem_address,
        output mem_wdata, mem_byte_enable,
        input  mem_resp, mem_rdata
    );

    modport slave (
        input  mem_read, mem_write, mem_address,
        input  mem_wdata, mem_byte_enable,
        output mem_resp, mem_rdata
    );

endinterface

// File: rtl/mem_access_unit_align.sv
// Byte-lane steering: replicates store bytes, extracts and
// sign-extends load bytes. Purely combinational.
import mem_access_unit_pkg::*;

module mem_align (
    input  lc3b_memop     memop,
    input  logic [15:0]   addr,
    input  logic [15:0]   sdata,
    input  logic [15:0]   rdata,
    output logic [15:0]   wdata,
    output lc3b_mem_wmask wmask,
    output logic [15:0]   ldata
);

    logic [7:0] lbyte;

    assign lbyte = addr[0] ? rdata[15:8] : rdata[7:0];

    always_comb begin
        wdata = sdata;
        wmask = 2'b11;
        ldata = rdata;
        if (memop == STB) begin
            wdata = {sdata[7:0], sdata[7:0]};
            wmask = addr[0] ? 2'b10 : 2'b01;
        end
        if (memop == LDB) begin
            ldata = {{8{lbyte[7]}}, lbyte};
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// LC-3b MEM-stage access engine: runs one load/store (optionally
// indirect) per instruction, stalling the pipe until memory responds.
import mem_access_unit_pkg::*;

module mem_access_unit #(
    parameter int unsigned MAX_WAIT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  lc3b_memop         in_memop,
    input  logic [15:0]       in_addr,
    input  logic [15:0]       in_sdata,
    input  logic [15:0]       in_alu,
    input  logic [2:0]        in_dest,
    mem_access_unit_if.master mem,
    output logic              stall,
    output logic              out_valid,
    output logic [15:0]       out_data,
    output logic [2:0]        out_dest,
    output logic              err
);

    localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    lc3b_mau_state state;
    logic [15:0]   ptr;
    logic [CW-1:0] wait_cnt;
    logic          load;
    logic          indirect;
    logic          word;
    logic [15:0]   al_wdata;
    logic [15:0]   al_ldata;
    lc3b_mem_wmask al_wmask;

    assign load     = is_load(in_memop);
    assign indirect = is_indirect(in_memop);
    assign word     = !is_byte(in_memop);

    mem_align u_align (
        .memop (in_memop),
        .addr  (in_addr),
        .sdata (in_sdata),
        .rdata (mem.mem_rdata),
        .wdata (al_wdata),
        .wmask (al_wmask),
        .ldata (al_ldata)
    );

    // Requests decode from state alone; in_* are held while stalled.
    always_comb begin
        mem.mem_read        = 1'b0;
        mem.mem_write       = 1'b0;
        mem.mem_address     = {in_addr[15:1], 1'b0};
        mem.mem_wdata       = al_wdata;
        mem.mem_byte_enable = 2'b11;
        unique case (state)
            IND: mem.mem_read = 1'b1;
            ACC: begin
                mem.mem_read  = load;
                mem.mem_write = !load;
                if (indirect)
                    mem.mem_address = {ptr[15:1], 1'b0};
                else if (!word)
                    mem.mem_address = in_addr;
                if (!load)
                    mem.mem_byte_enable = al_wmask;
            end
            default: ;
        endcase
    end

    assign stall = in_valid && (in_memop != NONE)
                && !(state == ACC && mem.mem_resp);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    if (indirect)
                        state <= IND;
                    else if (in_memop != NONE)
                        state <= ACC;
                end
                IND: if (mem.mem_resp) begin
                    ptr   <= mem.mem_rdata;
                    state <= ACC;
                end
                ACC: if (mem.mem_resp)
                    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Counter saturates at MAX_WAIT so err needs no extra state.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (state == IDLE || mem.mem_resp)
                wait_cnt <= '0;
            else if (wait_cnt != CW'(MAX_WAIT))
                wait_cnt <= wait_cnt + CW'(1);
            if (MAX_WAIT != 0 && state != IDLE
                && wait_cnt == CW'(MAX_WAIT))
                err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_dest  <= '0;
        end else if (!stall) begin
            out_valid <= in_valid;
            out_data  <= load ? al_ldata : in_alu;
            out_dest  <= in_dest;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a per-op schedule model.
// Each op is expanded into its expected cycle sequence and checked every cycle.
import mem_access_unit_pkg::*;

module tb_mem_access_unit;

    localparam int WD = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    lc3b_memop   in_memop = NONE;
    logic [15:0] in_addr = '0;
    logic [15:0] in_sdata = '0;
    logic [15:0] in_alu = '0;
    logic [2:0]  in_dest = '0;
    logic        stall, out_valid, err;
    logic [15:0] out_data;
    logic [2:0]  out_dest;

    mem_access_unit_if mif();

    mem_access_unit #(.MAX_WAIT(WD)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .in_memop(in_memop), .in_addr(in_addr), .in_sdata(in_sdata),
        .in_alu(in_alu), .in_dest(in_dest), .mem(mif),
        .stall(stall), .out_valid(out_valid), .out_data(out_data),
        .out_dest(out_dest), .err(err)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int miss = 0;
    logic chk = 1'b0;
    logic e_stall, e_rd, e_wr, e_ov, e_err;
    logic [15:0] e_addr, e_wd, e_od;
    logic [1:0]  e_be;
    logic [2:0]  e_odest;
    int occ;
    logic [15:0] last_addr, last_wd;
    logic [1:0]  last_be;

    task automatic check(input string n, input logic [15:0] act, input logic [15:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (chk) begin
        check("stall", 16'(stall), 16'(e_stall));
        check("mem_read", 16'(mif.mem_read), 16'(e_rd));
        check("mem_write", 16'(mif.mem_write), 16'(e_wr));
        if (e_rd || e_wr) begin
            check("mem_address", mif.mem_address, e_addr);
            check("byte_enable", 16'(mif.mem_byte_enable), 16'(e_be));
        end
        if (e_wr) check("mem_wdata", mif.mem_wdata, e_wd);
        check("out_valid", 16'(out_valid), 16'(e_ov));
        check("out_data", out_data, e_od);
        check("out_dest", 16'(out_dest), 16'(e_odest));
        check("err", 16'(err), 16'(e_err));
    end

    function automatic logic [15:0] ld_val(lc3b_memop op, logic [15:0] a, logic [15:0] d);
        logic [7:0] b;
        b = a[0] ? d[15:8] : d[7:0];
        return (op == LDB) ? 16'($signed(b)) : d;
    endfunction

    // One clock of the schedule: drive memory side, set expectations, advance.
    task automatic cyc(input logic resp, input logic [15:0] rd, input logic es,
                       input logic erd, input logic ewr, input logic [15:0] ea,
                       input logic [15:0] ewd, input logic [1:0] ebe,
                       input int widx, input logic [15:0] res);
        mif.mem_resp = resp;
        mif.mem_rdata = rd;
        e_stall = es; e_rd = erd; e_wr = ewr;
        e_addr = ea; e_wd = ewd; e_be = ebe;
        @(negedge clk);
        if (stall) occ++;
        if (mif.mem_read || mif.mem_write) begin
            last_addr = mif.mem_address;
            last_wd = mif.mem_wdata;
            last_be = mif.mem_byte_enable;
        end
        @(posedge clk);
        if (reset) begin
            e_ov = 1'b0; e_od = '0; e_odest = '0; e_err = 1'b0;
        end else begin
            if (!es) begin
                e_ov = in_valid; e_od = res; e_odest = in_dest;
            end
            if (widx >= WD) e_err = 1'b1;
        end
        #1;
    endtask

    // Full op; returns the number of cycles it occupies the stage.
    task automatic run_op(input lc3b_memop op, input logic [15:0] a, input logic [15:0] s,
                          input logic [15:0] alu, input logic [2:0] d,
                          input int w1, input int w2, input logic [15:0] pv,
                          input logic [15:0] dv, output int cycles);
        logic ld, ind, byt;
        logic [15:0] fa, wd, res;
        logic [1:0] be;
        ld = op inside {LDW, LDB, LDI};
        ind = op inside {LDI, STI};
        byt = op inside {LDB, STB};
        in_valid = 1'b1; in_memop = op; in_addr = a;
        in_sdata = s; in_alu = alu; in_dest = d;
        occ = 0;
        if (op == NONE) begin
            cyc(1'($urandom_range(0, 1)), 16'($urandom), 1'b0, 1'b0, 1'b0,
                '0, '0, '0, -1, alu);
        end else begin
            fa = ind ? {pv[15:1], 1'b0} : (byt ? a : {a[15:1], 1'b0});
            res = ld ? ld_val(op, a, dv) : alu;
            wd = byt ? {s[7:0], s[7:0]} : s;
            be = (!ld && byt) ? (a[0] ? 2'b10 : 2'b01) : 2'b11;
            cyc(1'($urandom_range(0, 1)), 16'($urandom), 1'b1, 1'b0, 1'b0,
                '0, '0, '0, -1, '0);
            if (ind)
                for (int k = 0; k <= w1; k++)
                    cyc(k == w1, (k == w1) ? pv : 16'($urandom), 1'b1, 1'b1, 1'b0,
                        {a[15:1], 1'b0}, '0, 2'b11, k, '0);
            for (int k = 0; k <= w2; k++)
                cyc(k == w2, (k == w2) ? dv : 16'($urandom), k != w2, ld, !ld,
                    fa, wd, be, k, res);
        end
        cycles = occ + 1;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_memop = NONE;
        in_alu = 16'($urandom); in_dest = 3'($urandom);
        cyc(1'($urandom_range(0, 1)), 16'($urandom), 1'b0, 1'b0, 1'b0,
            '0, '0, '0, -1, in_alu);
    endtask

    initial begin
        int n;
        lc3b_memop op;
        mif.mem_resp = 1'b0;
        mif.mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        e_ov = 1'b0; e_od = '0; e_odest = '0; e_err = 1'b0;
        chk = 1'b1;
        cyc(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, '0, '0, '0, -1, '0);
        reset = 1'b0;

        run_op(LDW, 16'h1235, 16'h0, 16'h0, 3'd1, 0, 0, 16'h0, 16'hBEEF, n);
        check("ldw_cycles", 16'(n), 16'd2);
        check("ldw_addr", last_addr, 16'h1234);
        check("ldw_data", out_data, 16'hBEEF);
        run_op(LDB, 16'h2001, 16'h0, 16'h0, 3'd2, 0, 0, 16'h0, 16'h80FF, n);
        check("ldb_hi", out_data, 16'hFF80);
        run_op(LDB, 16'h2000, 16'h0, 16'h0, 3'd2, 0, 1, 16'h0, 16'h80FF, n);
        check("ldb_lo", out_data, 16'hFFFF);
        run_op(STB, 16'h3003, 16'h00A5, 16'h0042, 3'd3, 0, 2, 16'h0, 16'h0, n);
        check("stb_be", 16'(last_be), 16'h0002);
        check("stb_wdata", last_wd, 16'hA5A5);
        check("stb_addr", last_addr, 16'h3003);
        check("stb_data", out_data, 16'h0042);
        run_op(LDI, 16'h4000, 16'h0, 16'h0, 3'd4, 3, 3, 16'h5002, 16'h1111, n);
        check("ldi_cycles", 16'(n), 16'd9);
        check("ldi_addr", last_addr, 16'h5002);
        check("ldi_data", out_data, 16'h1111);
        run_op(NONE, 16'h0, 16'h0, 16'h0007, 3'd5, 0, 0, 16'h0, 16'h0, n);
        run_op(NONE, 16'h0, 16'h0, 16'h0007, 3'd5, 0, 0, 16'h0, 16'h0, n);
        check("none_cycles", 16'(n), 16'd1);
        check("none_data", out_data, 16'h0007);

        run_op(LDW, 16'h0100, 16'h0, 16'h0, 3'd6, 0, 6, 16'h0, 16'h5A5A, n);
        check("wd_err", 16'(err), 16'h0001);
        idle();

        // Reset lands in ACC together with a response.
        in_valid = 1'b1; in_memop = LDW; in_addr = 16'h6000; in_dest = 3'd7;
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, '0, '0, '0, -1, '0);
        for (int k = 0; k < 3; k++)
            cyc(1'b0, 16'($urandom), 1'b1, 1'b1, 1'b0, 16'h6000, '0, 2'b11, k, '0);
        reset = 1'b1;
        cyc(1'b1, 16'hCAFE, 1'b0, 1'b1, 1'b0, 16'h6000, '0, 2'b11, 3, 16'hCAFE);
        reset = 1'b0; in_valid = 1'b0; in_memop = NONE;
        check("rst_read", 16'(mif.mem_read), 16'h0);
        check("rst_err", 16'(err), 16'h0);
        check("rst_valid", 16'(out_valid), 16'h0);
        idle();

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            op = lc3b_memop'($urandom_range(0, 6));
            run_op(op, 16'($urandom), 16'($urandom), 16'($urandom), 3'($urandom),
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   16'($urandom), 16'($urandom), n);
        end
        idle();
        chk = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
